subtrator_serial: RTL and testbench

Multi-cycle 44-bit unsigned subtractor, the inverse-operation companion to the registered adder in the arithmetic datapath. It computes s = a − b in CHUNK-bit slices, one slice per clock, with a ripple borrow between slices. Completion is signalled with a start/busy/done handshake, and a borrow flag and a zero flag are reported with the result. It trades latency for a narrow carry chain and feeds downstream compare and accumulate logic.

---
 rtl/subtrator_serial.sv | 136 +++++++++++++
 tb/tb_subtrator_serial.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/subtrator_serial.sv
// Multi-cycle unsigned subtractor: computes s = a - b one CHUNK-bit slice per
// clock with a rippled borrow, using a start/busy/done handshake.
module subtrator_serial #(
    parameter int unsigned WIDTH = 44,
    parameter int unsigned CHUNK = 11
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             borrow,
    output logic             zero
);

    localparam int unsigned NSLICE = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned SW     = CHUNK + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              bin_q, bin_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              borrow_q, borrow_d;
    logic              zero_q, zero_d;

    logic [31:0]       lo_c;
    logic [SW-1:0]     diff_c;
    logic              last_c;

    // Slice arithmetic for the slice currently selected by idx.
    always_comb begin
        lo_c   = 32'(idx_q) * 32'(CHUNK);
        diff_c = {1'b0, a_q[lo_c +: CHUNK]} - {1'b0, b_q[lo_c +: CHUNK]} - SW'(bin_q);
        last_c = (idx_q == IDXW'(NSLICE - 1));
    end

    // State register and all datapath/output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            s_q      <= '0;
            idx_q    <= '0;
            bin_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            s_q      <= s_d;
            idx_q    <= idx_d;
            bin_q    <= bin_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
        end
    end

    // Next-state and next-output logic; published results only move on completion.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        s_d      = s_q;
        idx_d    = idx_q;
        bin_d    = bin_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        borrow_d = borrow_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    bin_d   = 1'b0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d[lo_c +: CHUNK] = diff_c[CHUNK-1:0];
                bin_d = diff_c[CHUNK];
                idx_d = IDXW'(idx_q + 1'b1);
                if (last_c) begin
                    s_d      = acc_d;
                    borrow_d = diff_c[CHUNK];
                    zero_d   = (acc_d == '0);
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    idx_d    = '0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign s      = s_q;
    assign borrow = borrow_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_subtrator_serial.sv
// Directed-vector bench for subtrator_serial.
module tb_subtrator_serial;

    localparam int unsigned WIDTH = 44;

    logic             clock;
    logic             reset_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             borrow;
    logic             zero;

    int n_vec;
    int n_err;

    subtrator_serial #(.WIDTH(44), .CHUNK(11)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .s      (s),
        .borrow (borrow),
        .zero   (zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Run one operation from IDLE and check latency, busy window and results.
    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic [WIDTH-1:0] es, input logic eb, input logic ez);
        int n;
        @(negedge clock);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clock);
        #1;
        check_val("busy_accept", 64'(busy), 64'd1);
        start = 1'b0;
        a     = {12'($urandom), 32'($urandom)};
        b     = {12'($urandom), 32'($urandom)};
        n = 0;
        while (done !== 1'b1 && n < 10) begin
            @(posedge clock);
            #1;
            n++;
            if (done !== 1'b1) check_val("busy_calc", 64'(busy), 64'd1);
        end
        check_val("latency", 64'(n), 64'd4);
        check_val("busy_done", 64'(busy), 64'd0);
        check_val("s", 64'(s), 64'(es));
        check_val("borrow", 64'(borrow), 64'(eb));
        check_val("zero", 64'(zero), 64'(ez));
        @(posedge clock);
        #1;
        check_val("done_pulse", 64'(done), 64'd0);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset_n = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        #1 reset_n = 1'b0;
        #1;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_s", 64'(s), 64'd0);
        check_val("rst_borrow", 64'(borrow), 64'd0);
        check_val("rst_zero", 64'(zero), 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        do_op(44'd4, 44'd8, 44'hFFFFFFFFFFC, 1'b1, 1'b0);
        do_op(44'd40, 44'd11, 44'd29, 1'b0, 1'b0);
        do_op(44'd38, 44'd38, 44'd0, 1'b0, 1'b1);
        do_op(44'h800, 44'h001, 44'h7FF, 1'b0, 1'b0);
        do_op(44'd0, 44'd1, 44'hFFFFFFFFFFF, 1'b1, 1'b0);
        do_op(44'h80000000000, 44'd1, 44'h7FFFFFFFFFF, 1'b0, 1'b0);

        // start held high: second accept at k+6, a/b changed before k+2.
        @(negedge clock);
        start = 1'b1;
        a     = 44'd100;
        b     = 44'd1;
        @(posedge clock);
        #1;
        check_val("hold_busy_k", 64'(busy), 64'd1);
        for (int e = 1; e <= 10; e++) begin
            @(posedge clock);
            #1;
            if (e == 1) begin
                a = 44'd7;
                b = 44'd9;
            end
            check_val("hold_busy", 64'(busy), 64'(((e >= 1 && e <= 3) || (e >= 6 && e <= 9)) ? 1 : 0));
            check_val("hold_done", 64'(done), 64'((e == 4 || e == 10) ? 1 : 0));
            if (e == 4) check_val("hold_s1", 64'(s), 64'd99);
            if (e == 10) begin
                check_val("hold_s2", 64'(s), 64'hFFFFFFFFFFE);
                check_val("hold_borrow2", 64'(borrow), 64'd1);
            end
        end
        start = 1'b0;
        @(posedge clock);
        #1;

        // Published result stays stable while idle.
        do_op(44'd40, 44'd11, 44'd29, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            a = {12'($urandom), 32'($urandom)};
            b = {12'($urandom), 32'($urandom)};
            @(posedge clock);
            #1;
            check_val("stable_s", 64'(s), 64'd29);
            check_val("stable_borrow", 64'(borrow), 64'd0);
            check_val("stable_zero", 64'(zero), 64'd0);
            check_val("stable_done", 64'(done), 64'd0);
        end

        // Reset in the middle of CALC aborts the operation.
        @(negedge clock);
        start = 1'b1;
        a     = 44'd40;
        b     = 44'd11;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_val("abort_s", 64'(s), 64'd0);
        check_val("abort_borrow", 64'(borrow), 64'd0);
        check_val("abort_zero", 64'(zero), 64'd0);
        check_val("abort_busy", 64'(busy), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            check_val("abort_no_done", 64'(done), 64'd0);
        end
        do_op(44'd5, 44'd4, 44'd1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Handshake invariant checked on every falling edge.
    always @(negedge clock) begin
        if (reset_n && busy === 1'b1 && done === 1'b1) begin
            check_val("busy_and_done", 64'd1, 64'd0);
        end
    end

endmodule
